// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath (master) and the stall/flush sequencer (slave).
// The datapath drives the hazard sources; the sequencer returns the pipeline-register hold/bubble controls.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] id_rs1_addr_i;
  logic              id_rs1_re_i;
  logic [REG_AW-1:0] id_rs2_addr_i;
  logic              id_rs2_re_i;
  logic [REG_AW-1:0] exe_rd_addr_i;
  logic              exe_rd_we_i;
  logic              exe_mem_re_i;
  logic              exe_redirect_i;
  logic              exe_busy_i;
  logic              dmem_ready_i;
  logic              mem_access_i;

  logic              pc_stall_o;
  logic              if_id_stall_o;
  logic              if_id_flush_o;
  logic              id_exe_stall_o;
  logic              id_exe_flush_o;
  logic              exe_mem_stall_o;
  logic              exe_mem_flush_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
           exe_rd_addr_i, exe_rd_we_i, exe_mem_re_i, exe_redirect_i,
           exe_busy_i, dmem_ready_i, mem_access_i,
    input  pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o,
           id_exe_flush_o, exe_mem_stall_o, exe_mem_flush_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs1_addr_i, id_rs1_re_i, id_rs2_addr_i, id_rs2_re_i,
           exe_rd_addr_i, exe_rd_we_i, exe_mem_re_i, exe_redirect_i,
           exe_busy_i, dmem_ready_i, mem_access_i,
    output pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_stall_o,
           id_exe_flush_o, exe_mem_stall_o, exe_mem_flush_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: boot hold, data-memory wait, redirect flush,
// multi-cycle EXE hold and load-use bubble, plus saturating stall/redirect counters.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int BOOT_CYCLES = 4,
  parameter int REDIR_FLUSH = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {BOOT, RUN, MEM_WAIT, REDIRECT} state_e;

  localparam logic [REG_AW-1:0] REG_X0     = '0;
  localparam logic [3:0]        BOOT_LAST  = 4'(BOOT_CYCLES - 1);
  localparam logic [1:0]        REDIR_INIT = 2'(REDIR_FLUSH - 1);

  state_e           state_q, state_d;
  logic [3:0]       boot_cnt_q, boot_cnt_d;
  logic [1:0]       redir_cnt_q, redir_cnt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memw, load_use, redir_go;
  logic pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
  logic exe_mem_stall, exe_mem_flush;

  assign memw     = hz.mem_access_i & ~hz.dmem_ready_i;
  // A redirect that arrived while memory was stalling is replayed as soon as the wait ends.
  assign redir_go = hz.exe_redirect_i | redir_pend_q;
  assign load_use = hz.exe_mem_re_i & hz.exe_rd_we_i & (hz.exe_rd_addr_i != REG_X0) &
                    ((hz.id_rs1_re_i & (hz.id_rs1_addr_i == hz.exe_rd_addr_i)) |
                     (hz.id_rs2_re_i & (hz.id_rs2_addr_i == hz.exe_rd_addr_i)));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    state_d       = state_q;
    boot_cnt_d    = boot_cnt_q;
    redir_cnt_d   = redir_cnt_q;
    redir_pend_d  = redir_pend_q;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_stall  = 1'b0;
    id_exe_flush  = 1'b0;
    exe_mem_stall = 1'b0;
    exe_mem_flush = 1'b0;

    case (state_q)
      BOOT: begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
        id_exe_flush = 1'b1;
        boot_cnt_d   = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      default: begin
        if (memw) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_exe_stall  = 1'b1;
          exe_mem_stall = 1'b1;
          redir_pend_d  = redir_pend_q | hz.exe_redirect_i;
          state_d       = MEM_WAIT;
        end else if (redir_go) begin
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          redir_pend_d = 1'b0;
          redir_cnt_d  = REDIR_INIT;
          state_d      = (REDIR_FLUSH > 1) ? REDIRECT : RUN;
        end else if (state_q == REDIRECT) begin
          if_id_flush  = 1'b1;
          id_exe_flush = 1'b1;
          redir_cnt_d  = redir_cnt_q - 2'd1;
          state_d      = (redir_cnt_q <= 2'd1) ? RUN : REDIRECT;
        end else begin
          state_d = RUN;
          if (hz.exe_busy_i) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_exe_stall  = 1'b1;
            exe_mem_flush = 1'b1;
          end else if (load_use) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_exe_flush = 1'b1;
          end
        end
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if ((state_q != BOOT) && hz.exe_redirect_i && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= BOOT;
      boot_cnt_q   <= '0;
      redir_cnt_q  <= '0;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      redir_cnt_q  <= redir_cnt_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign hz.pc_stall_o      = pc_stall;
  assign hz.if_id_stall_o   = if_id_stall;
  assign hz.if_id_flush_o   = if_id_flush;
  assign hz.id_exe_stall_o  = id_exe_stall;
  assign hz.id_exe_flush_o  = id_exe_flush;
  assign hz.exe_mem_stall_o = exe_mem_stall;
  // EXE_MEM is bubbled while reset is held; once released, boot only needs the front end cleared.
  assign hz.exe_mem_flush_o = exe_mem_flush | ~rst_ni;
  assign hz.stall_cnt_o     = stall_cnt_q;
  assign hz.flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: inputs change on the falling edge, outputs are checked
// 1 ns later against hand-computed control vectors and counter values.
module tb_pipe_hazard_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();

  pipe_hazard_ctrl #(
    .REG_AW(5), .BOOT_CYCLES(4), .REDIR_FLUSH(2), .CNT_W(32)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .hz    (hz)
  );

  // Packed as {pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush, exe_mem_stall, exe_mem_flush}
  localparam logic [6:0] O_RST   = 7'b1010101;
  localparam logic [6:0] O_BOOT  = 7'b1010100;
  localparam logic [6:0] O_NONE  = 7'b0000000;
  localparam logic [6:0] O_MEMW  = 7'b1101010;
  localparam logic [6:0] O_REDIR = 7'b0010100;
  localparam logic [6:0] O_BUSY  = 7'b1101001;
  localparam logic [6:0] O_LU    = 7'b1100100;

  logic [6:0] ctl;
  assign ctl = {hz.pc_stall_o, hz.if_id_stall_o, hz.if_id_flush_o, hz.id_exe_stall_o,
                hz.id_exe_flush_o, hz.exe_mem_stall_o, hz.exe_mem_flush_o};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hz.id_rs1_addr_i  = '0;
    hz.id_rs1_re_i    = 1'b0;
    hz.id_rs2_addr_i  = '0;
    hz.id_rs2_re_i    = 1'b0;
    hz.exe_rd_addr_i  = '0;
    hz.exe_rd_we_i    = 1'b0;
    hz.exe_mem_re_i   = 1'b0;
    hz.exe_redirect_i = 1'b0;
    hz.exe_busy_i     = 1'b0;
    hz.dmem_ready_i   = 1'b1;
    hz.mem_access_i   = 1'b0;
  endtask

  task automatic exe_load(input logic [4:0] rd);
    hz.exe_rd_addr_i = rd;
    hz.exe_rd_we_i   = 1'b1;
    hz.exe_mem_re_i  = 1'b1;
  endtask

  task automatic cyc_check(input string tag, input logic [6:0] exp);
    #1 check(tag, {25'b0, ctl}, {25'b0, exp});
  endtask

  task automatic release_and_boot();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      cyc_check($sformatf("boot%0d", i), O_BOOT);
    end
    @(negedge clk);
    cyc_check("boot_done", O_NONE);
    check("stall_cnt_boot", hz.stall_cnt_o, 32'd4);
    check("flush_cnt_boot", hz.flush_cnt_o, 32'd0);
  endtask

  initial begin
    idle();
    #3;
    check("rst_ctl", {25'b0, ctl}, {25'b0, O_RST});
    check("rst_stall_cnt", hz.stall_cnt_o, 32'd0);
    release_and_boot();

    // Load-use on rs1, then EXE holds a non-load: exactly one bubble.
    @(negedge clk); exe_load(5'd5); hz.id_rs1_addr_i = 5'd5; hz.id_rs1_re_i = 1'b1;
    cyc_check("lu_rs1", O_LU);
    @(negedge clk); hz.exe_mem_re_i = 1'b0;
    cyc_check("lu_after", O_NONE);
    check("stall_cnt_lu", hz.stall_cnt_o, 32'd5);
    @(negedge clk); exe_load(5'd0); hz.id_rs1_addr_i = 5'd0;
    cyc_check("lu_x0", O_NONE);
    @(negedge clk); exe_load(5'd7); hz.id_rs1_addr_i = 5'd3; hz.id_rs2_addr_i = 5'd7; hz.id_rs2_re_i = 1'b1;
    cyc_check("lu_rs2", O_LU);
    @(negedge clk); hz.id_rs2_re_i = 1'b0;
    cyc_check("lu_rs2_noread", O_NONE);
    @(negedge clk); hz.id_rs2_re_i = 1'b1; hz.exe_mem_re_i = 1'b0;
    cyc_check("lu_not_load", O_NONE);
    check("stall_cnt_lu2", hz.stall_cnt_o, 32'd6);

    // Redirect pulse: two flush cycles.
    @(negedge clk); idle(); hz.exe_redirect_i = 1'b1;
    cyc_check("redir_c0", O_REDIR);
    @(negedge clk); hz.exe_redirect_i = 1'b0;
    cyc_check("redir_c1", O_REDIR);
    check("flush_cnt_1", hz.flush_cnt_o, 32'd1);
    @(negedge clk);
    cyc_check("redir_done", O_NONE);

    // Memory wait for 3 cycles with a redirect in the 2nd: stalls, then deferred flush.
    @(negedge clk); hz.mem_access_i = 1'b1; hz.dmem_ready_i = 1'b0;
    cyc_check("memw_c0", O_MEMW);
    @(negedge clk); hz.exe_redirect_i = 1'b1;
    cyc_check("memw_c1_redir", O_MEMW);
    @(negedge clk); hz.exe_redirect_i = 1'b0;
    cyc_check("memw_c2", O_MEMW);
    @(negedge clk); hz.dmem_ready_i = 1'b1;
    cyc_check("memw_replay0", O_REDIR);
    check("flush_cnt_2", hz.flush_cnt_o, 32'd2);
    @(negedge clk); hz.mem_access_i = 1'b0;
    cyc_check("memw_replay1", O_REDIR);
    @(negedge clk);
    cyc_check("memw_done", O_NONE);
    check("stall_cnt_memw", hz.stall_cnt_o, 32'd9);

    // Back-to-back redirects restart the flush window.
    @(negedge clk); hz.exe_redirect_i = 1'b1;
    cyc_check("rr_c0", O_REDIR);
    @(negedge clk);
    cyc_check("rr_c1", O_REDIR);
    @(negedge clk); hz.exe_redirect_i = 1'b0;
    cyc_check("rr_c2", O_REDIR);
    @(negedge clk);
    cyc_check("rr_done", O_NONE);
    check("flush_cnt_4", hz.flush_cnt_o, 32'd4);

    // Busy EXE for 5 cycles masks a pending load-use, which then costs one bubble.
    @(negedge clk); exe_load(5'd9); hz.id_rs1_addr_i = 5'd9; hz.id_rs1_re_i = 1'b1; hz.exe_busy_i = 1'b1;
    cyc_check("busy_c0", O_BUSY);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      cyc_check($sformatf("busy_c%0d", i), O_BUSY);
    end
    @(negedge clk); hz.exe_busy_i = 1'b0;
    cyc_check("busy_then_lu", O_LU);
    @(negedge clk); hz.exe_mem_re_i = 1'b0;
    cyc_check("busy_lu_done", O_NONE);
    check("stall_cnt_busy", hz.stall_cnt_o, 32'd15);

    // Asynchronous reset in the middle of a redirect window.
    @(negedge clk); idle(); hz.exe_redirect_i = 1'b1;
    cyc_check("pre_rst_redir", O_REDIR);
    @(negedge clk); hz.exe_redirect_i = 1'b0;
    cyc_check("pre_rst_redir1", O_REDIR);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {25'b0, ctl}, {25'b0, O_RST});
    check("async_rst_stall_cnt", hz.stall_cnt_o, 32'd0);
    check("async_rst_flush_cnt", hz.flush_cnt_o, 32'd0);
    @(negedge clk);
    release_and_boot();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage core; drives hold/bubble controls of PC, IF_ID, ID_EXE and EXE_MEM pipeline registers.
- Detects load-use hazards (ID consumer vs EXE load), branch/jump redirects, multi-cycle EXE ops and data-memory wait, and sequences them with a small FSM plus cycle counters.
- Sits beside the datapath; all outputs are consumed by the pipeline-register enables in the same cycle.

Parameters:
- REG_AW, 5, GPR address width (matches GPR address space).
- BOOT_CYCLES, 4, cycles PC held after reset release (1..15).
- REDIR_FLUSH, 2, cycles IF_ID and ID_EXE are flushed after a redirect (1..3).
- CNT_W, 32, width of the saturating performance counters.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- id_rs1_addr_i  in  REG_AW  ID-stage rs1 address
- id_rs1_re_i  in  1  ID reads rs1
- id_rs2_addr_i  in  REG_AW  ID-stage rs2 address
- id_rs2_re_i  in  1  ID reads rs2
- exe_rd_addr_i  in  REG_AW  EXE-stage destination
- exe_rd_we_i  in  1  EXE writes rd
- exe_mem_re_i  in  1  EXE instruction is a load
- exe_redirect_i  in  1  EXE resolved taken branch/jump (1-cycle pulse)
- exe_busy_i  in  1  multi-cycle EXE unit not done
- dmem_ready_i  in  1  data memory accepted/returned access
- mem_access_i  in  1  MEM stage holds load/store
- pc_stall_o  out  1  hold PC
- if_id_stall_o  out  1  hold IF_ID
- if_id_flush_o  out  1  load NOP into IF_ID
- id_exe_stall_o  out  1  hold ID_EXE
- id_exe_flush_o  out  1  load bubble into ID_EXE (rd_we/mem_we/mem_re = 0)
- exe_mem_stall_o  out  1  hold EXE_MEM
- exe_mem_flush_o  out  1  bubble into EXE_MEM
- stall_cnt_o  out  CNT_W  cycles with pc_stall_o=1 (saturating)
- flush_cnt_o  out  CNT_W  redirect events (saturating)

Behaviour:
- FSM states: BOOT, RUN, MEM_WAIT, REDIRECT. Reset (async, rst_ni=0) -> BOOT, boot counter=0, redirect counter=0, both perf counters=0.
- Outputs are combinational from state + inputs; state/counters update on posedge clk_i.
- Reset output values (rst_ni=0): pc_stall_o=1, if_id_flush_o=1, id_exe_flush_o=1, exe_mem_flush_o=1, all stall_o other than pc=0, counters=0.
- BOOT: pc_stall_o=1, if_id_flush_o=1, id_exe_flush_o=1; after BOOT_CYCLES edges -> RUN. Inputs ignored.
- MEM_WAIT condition memw = mem_access_i & ~dmem_ready_i. Highest priority in RUN/REDIRECT: assert all four stalls (pc, IF_ID, ID_EXE, EXE_MEM), no flushes; state -> MEM_WAIT; leave to RUN on first cycle memw=0 (that cycle already behaves as RUN).
- Redirect (exe_redirect_i=1, no memw): if_id_flush_o=1, id_exe_flush_o=1 this cycle, no stalls; next state REDIRECT with counter=REDIR_FLUSH-1. In REDIRECT: flushes held while counter!=0, decrement each cycle; counter 0 -> RUN. REDIR_FLUSH=1 returns to RUN directly. flush_cnt_o += 1 per redirect pulse.
- Redirect arriving during MEM_WAIT is not lost: latched and executed on the first cycle memw=0.
- New redirect inside REDIRECT restarts the counter and increments flush_cnt_o.
- exe_busy (RUN, no memw, no redirect): pc/IF_ID/ID_EXE stall, exe_mem_flush_o=1.
- Load-use lu = exe_mem_re_i & exe_rd_we_i & exe_rd_addr_i!=0 & ((id_rs1_re_i & rs1 match) | (id_rs2_re_i & rs2 match)). In RUN with none above: pc_stall_o=1, if_id_stall_o=1, id_exe_flush_o=1. Exactly one bubble results since EXE then holds a non-load.
- Priority: reset > BOOT > memw > redirect > exe_busy > load-use > none. A stall and flush of the same register are never both 1; flush wins only via priority above.
- x0 never causes hazards. Counters saturate at all-ones; stall_cnt_o counts every cycle pc_stall_o=1 including BOOT.
- Reset mid-operation: immediate return to BOOT state and reset values regardless of state.

Test Plan:
- Reset release, idle inputs -> pc_stall_o=1 for exactly 4 edges, then 0; stall_cnt_o=4.
- EXE load rd=5, ID add rs1=5 rs1_re=1 -> one cycle pc_stall_o=if_id_stall_o=id_exe_flush_o=1; same with rd=0 -> no stall.
- exe_redirect_i pulse with REDIR_FLUSH=2 -> if_id_flush_o/id_exe_flush_o high 2 cycles, flush_cnt_o=1.
- mem_access_i=1, dmem_ready_i low 3 cycles plus redirect pulse in cycle 2 -> all stalls 3 cycles, then 2 flush cycles, flush_cnt_o=1.
- exe_busy_i high 5 cycles with concurrent load-use -> 5 cycles of stalls with exe_mem_flush_o=1, then load-use bubble 1 cycle.
- rst_ni low during REDIRECT -> outputs return to reset values asynchronously; BOOT resequenced.
